// File: rtl/vecmac_accumulator.sv
// ============================================================================
//  Module   : vecmac_accumulator
//  Purpose  : Signed dot-product accumulator for the int8 vector-MAC datapath.
//             It takes one unsigned product per valid cycle and applies a
//             per-element sign. VEC_LEN terms are summed. Each completed
//             result goes out through a single-entry valid/ready register.
//             The upstream multiplier cannot be stalled, so a result that
//             finds the output register occupied is dropped, and a sticky
//             error flag is raised.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module vecmac_accumulator #(
  parameter int VEC_LEN = 8,
  parameter int PROD_W  = 16,
  parameter int ACC_W   = 24,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [PROD_W-1:0] in_product,
  input  logic              in_neg,
  input  logic              acc_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic              drop_err,
  output logic              busy,
  output logic [CNT_W-1:0]  elem_cnt
);

  // Index of the final element of a vector, in counter width.
  localparam logic [CNT_W-1:0] C_LAST_IDX = CNT_W'(VEC_LEN - 1);

  // --------------------------------------------------------------------------
  // Registered state
  // --------------------------------------------------------------------------
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_out_valid;
  logic [ACC_W-1:0] r_out_sum;
  logic             r_drop_err;

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic [ACC_W-1:0] w_mag;       // zero-extended product magnitude
  logic [ACC_W-1:0] w_term;      // signed contribution of this element
  logic [ACC_W-1:0] w_base_acc;  // partial sum this element builds on
  logic [CNT_W-1:0] w_base_cnt;  // element count this element builds on
  logic [ACC_W-1:0] w_result;    // partial sum including this element
  logic             w_last;      // this element completes the vector
  logic             w_complete;  // a completed result is produced this cycle
  logic             w_accept;    // consumer takes the held result this cycle
  logic             w_can_load;  // output register can take a new result

  assign w_mag = ACC_W'(in_product);

  // Two's-complement negation is modulo 2^ACC_W, so no overflow handling is needed.
  assign w_term = in_neg ? (~w_mag + ACC_W'(1)) : w_mag;

  // acc_clr restarts the vector.
  // An element that arrives in the same cycle becomes element 0 of the new vector.
  assign w_base_acc = acc_clr ? '0 : r_acc;
  assign w_base_cnt = acc_clr ? '0 : r_cnt;

  assign w_result = w_base_acc + w_term;

  // With a single-element vector every valid element completes at once.
  // The accumulator then never holds a partial sum.
  generate
    if (VEC_LEN == 1) begin : g_single
      assign w_last = 1'b1;
    end else begin : g_multi
      assign w_last = (w_base_cnt == C_LAST_IDX);
    end
  endgenerate

  assign w_complete = in_valid & w_last;
  assign w_accept   = r_out_valid & out_ready;
  assign w_can_load = ~r_out_valid | out_ready;

  // --------------------------------------------------------------------------
  // Accumulator and element counter
  // --------------------------------------------------------------------------

  // Advance the partial sum on each valid element and restart it after completion or acc_clr.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (in_valid) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_result;
        r_cnt <= w_base_cnt + CNT_W'(1);
      end
    end else if (acc_clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end
  end

  // --------------------------------------------------------------------------
  // Output register (single entry, valid/ready)
  // --------------------------------------------------------------------------

  // Load a completed result when there is room.
  // Otherwise drop it and flag the loss; retire the held result on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sum   <= '0;
      r_drop_err  <= 1'b0;
    end else if (w_complete) begin
      if (w_can_load) begin
        r_out_valid <= 1'b1;
        r_out_sum   <= w_result;
      end else begin
        r_drop_err  <= 1'b1;
      end
    end else if (w_accept) begin
      // out_sum keeps its last value after it is consumed.
      r_out_valid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign out_valid = r_out_valid;
  assign out_sum   = r_out_sum;
  assign drop_err  = r_drop_err;
  assign elem_cnt  = r_cnt;
  assign busy      = (r_cnt != '0);

endmodule

`default_nettype wire

// File: tb/tb_vecmac_accumulator.sv
// ============================================================================
//  Module   : tb_vecmac_accumulator
//  Purpose  : Directed self-checking bench for vecmac_accumulator.
//             Expected values are hand-computed constants.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vecmac_accumulator;

  localparam int VEC_LEN = 8;
  localparam int PROD_W  = 16;
  localparam int ACC_W   = 24;
  localparam int CNT_W   = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [PROD_W-1:0] in_product;
  logic              in_neg;
  logic              acc_clr;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              drop_err;
  logic              busy;
  logic [CNT_W-1:0]  elem_cnt;

  int checks = 0;
  int errors = 0;

  vecmac_accumulator #(
    .VEC_LEN (VEC_LEN),
    .PROD_W  (PROD_W),
    .ACC_W   (ACC_W),
    .CNT_W   (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_product (in_product),
    .in_neg     (in_neg),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_sum    (out_sum),
    .drop_err   (drop_err),
    .busy       (busy),
    .elem_cnt   (elem_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one valid element for one clock. Return 1 time unit after the edge.
  task automatic send(input logic [PROD_W-1:0] p, input logic n);
    in_valid   = 1'b1;
    in_product = p;
    in_neg     = n;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    in_neg     = 1'b0;
  endtask

  // Run idle cycles.
  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_product = '0;
    in_neg     = 1'b0;
    acc_clr    = 1'b0;
    out_ready  = 1'b1;

    // Reset state
    do_reset();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum",   32'(out_sum),   32'd0);
    check("rst_drop_err",  32'(drop_err),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_elem_cnt",  32'(elem_cnt),  32'd0);

    // Eight contiguous elements of 100
    for (int i = 0; i < 7; i++) send(16'd100, 1'b0);
    check("c100_cnt7",  32'(elem_cnt),  32'd7);
    check("c100_busy",  32'(busy),      32'd1);
    check("c100_nvld",  32'(out_valid), 32'd0);
    send(16'd100, 1'b0);
    check("c100_valid", 32'(out_valid), 32'd1);
    check("c100_sum",   32'(out_sum),   32'd800);
    check("c100_cnt0",  32'(elem_cnt),  32'd0);
    check("c100_idle",  32'(busy),      32'd0);
    idle(1);
    check("c100_drop_valid", 32'(out_valid), 32'd0);
    check("c100_sum_hold",   32'(out_sum),   32'd800);

    // Maximum products with various signs
    for (int i = 0; i < 8; i++) send(16'd65025, 1'(i % 2));
    check("max_alt_sum", 32'(out_sum), 32'd0);
    check("max_alt_vld", 32'(out_valid), 32'd1);
    idle(1);
    for (int i = 0; i < 8; i++) send(16'd65025, 1'b0);
    check("max_pos_sum", 32'(out_sum), 32'd520200);
    idle(1);
    for (int i = 0; i < 8; i++) send(16'd65025, 1'b1);
    check("max_neg_sum", 32'(out_sum), 32'hF80FF8);
    idle(1);

    // Elements 1..8 separated by gaps of 0 to 3 idle cycles
    for (int i = 1; i <= 8; i++) begin
      send(PROD_W'(i), 1'b0);
      if (i < 8) begin
        check("gap_cnt_step", 32'(elem_cnt), 32'(i));
        idle(i % 4);
        check("gap_cnt_hold", 32'(elem_cnt), 32'(i));
      end
    end
    check("gap_sum",   32'(out_sum),   32'd36);
    check("gap_valid", 32'(out_valid), 32'd1);
    idle(1);

    // Back-to-back vectors with the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'd10, 1'b0);
    check("b2b_first_vld", 32'(out_valid), 32'd1);
    check("b2b_first_sum", 32'(out_sum),   32'd80);
    for (int i = 0; i < 8; i++) send(16'd20, 1'b0);
    check("b2b_held_sum", 32'(out_sum),   32'd80);
    check("b2b_held_vld", 32'(out_valid), 32'd1);
    check("b2b_drop_err", 32'(drop_err),  32'd1);
    out_ready = 1'b1;
    idle(1);
    check("b2b_accept", 32'(out_valid), 32'd0);
    for (int i = 0; i < 8; i++) send(16'd5, 1'b0);
    check("b2b_third_sum", 32'(out_sum),  32'd40);
    check("b2b_sticky",    32'(drop_err), 32'd1);
    idle(1);

    // Accept and completion in the same cycle
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'd10, 1'b0);
    for (int i = 0; i < 7; i++) send(16'd20, 1'b0);
    check("sim_hold_sum", 32'(out_sum), 32'd80);
    out_ready = 1'b1;
    send(16'd20, 1'b0);
    check("sim_sum",   32'(out_sum),   32'd160);
    check("sim_valid", 32'(out_valid), 32'd1);
    check("sim_nodrop", 32'(drop_err), 32'd0);
    idle(1);
    check("sim_retire", 32'(out_valid), 32'd0);

    // acc_clr together with a valid element
    for (int i = 0; i < 3; i++) send(16'd50, 1'b0);
    check("clr_pre_cnt", 32'(elem_cnt), 32'd3);
    acc_clr = 1'b1;
    send(16'd7, 1'b0);
    acc_clr = 1'b0;
    check("clr_cnt1",  32'(elem_cnt),  32'd1);
    check("clr_nvld",  32'(out_valid), 32'd0);
    for (int i = 0; i < 7; i++) send(16'd1, 1'b0);
    check("clr_sum",   32'(out_sum),   32'd14);
    check("clr_valid", 32'(out_valid), 32'd1);
    idle(1);

    // Reset in the middle of a vector while a result is held
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(16'd2, 1'b0);
    check("mrst_held", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) send(16'd9, 1'b0);
    rst = 1'b1;
    in_valid = 1'b1;
    in_product = 16'd9;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b0;
    check("mrst_cnt",   32'(elem_cnt),  32'd0);
    check("mrst_vld",   32'(out_valid), 32'd0);
    check("mrst_busy",  32'(busy),      32'd0);
    check("mrst_sum",   32'(out_sum),   32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(16'd3, 1'b0);
    check("mrst_next_sum", 32'(out_sum), 32'd24);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
